// File: rtl/axi_eth_rx_sts.sv
// ---------------------------------------------------------------------------
// axi_eth_rx_sts
//
// Purpose:
//    Sits after axi_eth_ifm in the s2mm_clk domain. Receive data beats pass
//    straight through to the S2MM DMA data channel with no added latency.
//    Alongside the data, the block counts the frame length and builds a raw
//    16-bit ones-complement checksum. Once the ifm status word for the frame
//    has been accepted, it sends a 6-word status (app) packet on the S2MM
//    status channel.
//
// Parameters:
//    C_CSUM_START  byte offset in the frame where checksum accumulation starts
//    C_STS_FLAG    value placed in word0[31:28] of every status packet
//
// Optional feature (compile-time macro):
//    AXI_ETH_RX_FRMCNT_EN  when defined, word5 carries a 32-bit count of
//                          completed status packets; otherwise word5 = 0
//
// Ports:
//    s2mm_clk, s2mm_resetn  clock, asynchronous active-low reset
//    s_rxd_*                frame data from the ifm (64-bit, tkeep/tlast)
//    s_rxs_*                per-frame ifm status word (bit31 = good frame)
//    m_rxd_*                frame data to the DMA
//    m_sts_*                6-word status packet to the DMA
// ---------------------------------------------------------------------------
module axi_eth_rx_sts #(
   parameter int         C_CSUM_START = 14,
   parameter logic [3:0] C_STS_FLAG   = 4'h5
) (
   input  logic        s2mm_clk,
   input  logic        s2mm_resetn,
   input  logic [63:0] s_rxd_tdata,
   input  logic [7:0]  s_rxd_tkeep,
   input  logic        s_rxd_tlast,
   input  logic        s_rxd_tvalid,
   output logic        s_rxd_tready,
   input  logic [31:0] s_rxs_tdata,
   input  logic        s_rxs_tvalid,
   output logic        s_rxs_tready,
   output logic [63:0] m_rxd_tdata,
   output logic [7:0]  m_rxd_tkeep,
   output logic        m_rxd_tlast,
   output logic        m_rxd_tvalid,
   input  logic        m_rxd_tready,
   output logic [31:0] m_sts_tdata,
   output logic [3:0]  m_sts_tkeep,
   output logic        m_sts_tlast,
   output logic        m_sts_tvalid,
   input  logic        m_sts_tready
);

   localparam logic [8:0] CSUM_START = 9'(C_CSUM_START);
   localparam logic [2:0] LAST_WORD  = 3'd5;

   typedef enum logic [1:0] {ST_DATA, ST_WAIT_RXS, ST_STS} state_t;

   state_t      state, state_next;
   logic        run_q;
   logic [15:0] length_q;
   logic [31:0] acc_q;
   logic [5:0]  beat_cnt_q;
   logic [2:0]  idx_q;
   logic        good_q;
   logic [15:0] csum_q;
   logic [31:0] frame_cnt;
   logic        rxd_fire;
   logic        rxs_fire;
   logic        sts_fire;
   logic [3:0]  beat_bytes;
   logic [31:0] beat_sum;
   logic [16:0] length_sum;
   logic [16:0] fold_sum;
   logic [15:0] csum_fold;
   logic        unused_rxs_bits;

   // Only the good-frame flag of the ifm status word is used.
   assign unused_rxs_bits = ^s_rxs_tdata[30:0];

   // Data fields pass straight through; only valid/ready are gated by state.
   assign m_rxd_tdata = s_rxd_tdata;
   assign m_rxd_tkeep = s_rxd_tkeep;
   assign m_rxd_tlast = s_rxd_tlast;

   assign rxd_fire = m_rxd_tvalid && m_rxd_tready;
   assign rxs_fire = s_rxs_tvalid && s_rxs_tready;
   assign sts_fire = m_sts_tvalid && m_sts_tready;

   // run_q clears asynchronously with reset and sets on the first clock
   // after release, so the combinational data path stays closed while reset
   // is held and opens on a clean clock edge afterwards.
   always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
      if (!s2mm_resetn) run_q <= 1'b0;
      else              run_q <= 1'b1;
   end

   // Per-beat byte count and checksum contribution. The absolute byte index
   // is {beat number, lane} because every non-last beat is full. Even lanes
   // are the high byte of a big-endian halfword, odd lanes the low byte.
   always_comb begin
      beat_bytes = 4'd0;
      beat_sum   = 32'd0;
      for (int l = 0; l < 8; l++) begin
         if (s_rxd_tkeep[l]) begin
            beat_bytes = beat_bytes + 4'd1;
            if ({beat_cnt_q, 3'(l)} >= CSUM_START) begin
               if ((l % 2) == 0) beat_sum = beat_sum + {16'h0, s_rxd_tdata[l*8 +: 8], 8'h00};
               else              beat_sum = beat_sum + {24'h0, s_rxd_tdata[l*8 +: 8]};
            end
         end
      end
      length_sum = {1'b0, length_q} + {13'h0, beat_bytes};
      fold_sum   = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
      csum_fold  = fold_sum[15:0] + {15'h0, fold_sum[16]};
   end

   // State register.
   always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
      if (!s2mm_resetn) state <= ST_DATA;
      else              state <= state_next;
   end

   // Next-state and handshake/output decode. The status word mux drives
   // zero outside STS so the bus is quiet between packets.
   always_comb begin
      state_next   = state;
      s_rxd_tready = 1'b0;
      m_rxd_tvalid = 1'b0;
      s_rxs_tready = 1'b0;
      m_sts_tvalid = 1'b0;
      m_sts_tkeep  = 4'h0;
      m_sts_tlast  = 1'b0;
      m_sts_tdata  = 32'h0;
      case (state)
         ST_DATA: begin
            s_rxd_tready = run_q && m_rxd_tready;
            m_rxd_tvalid = run_q && s_rxd_tvalid;
            if (rxd_fire && s_rxd_tlast) state_next = ST_WAIT_RXS;
         end
         ST_WAIT_RXS: begin
            s_rxs_tready = 1'b1;
            if (s_rxs_tvalid) state_next = ST_STS;
         end
         ST_STS: begin
            m_sts_tvalid = 1'b1;
            m_sts_tkeep  = 4'hF;
            m_sts_tlast  = (idx_q == LAST_WORD);
            case (idx_q)
               3'd0:    m_sts_tdata = {C_STS_FLAG, 28'h0};
               3'd3:    m_sts_tdata = {16'h0, csum_q};
               3'd4:    m_sts_tdata = {15'h0, good_q, length_q};
               3'd5:    m_sts_tdata = frame_cnt;
               default: m_sts_tdata = 32'h0;
            endcase
            if (m_sts_tready && (idx_q == LAST_WORD)) state_next = ST_DATA;
         end
         default: state_next = ST_DATA;
      endcase
   end

   // Frame accumulators and status sequencing. Length saturates rather
   // than wrapping; the beat counter only needs to reach the checksum start
   // offset, so it saturates too. Everything clears once word5 is taken.
   always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
      if (!s2mm_resetn) begin
         length_q   <= 16'h0;
         acc_q      <= 32'h0;
         beat_cnt_q <= 6'h0;
         idx_q      <= 3'd0;
         good_q     <= 1'b0;
         csum_q     <= 16'h0;
      end else begin
         if (rxd_fire) begin
            length_q <= length_sum[16] ? 16'hFFFF : length_sum[15:0];
            acc_q    <= acc_q + beat_sum;
            if (beat_cnt_q != 6'h3F) beat_cnt_q <= beat_cnt_q + 6'd1;
         end
         if (rxs_fire) begin
            good_q <= s_rxs_tdata[31];
            csum_q <= csum_fold;
            idx_q  <= 3'd0;
         end
         if (sts_fire) begin
            if (idx_q == LAST_WORD) begin
               idx_q      <= 3'd0;
               length_q   <= 16'h0;
               acc_q      <= 32'h0;
               beat_cnt_q <= 6'h0;
            end else begin
               idx_q <= idx_q + 3'd1;
            end
         end
      end
   end

`ifdef AXI_ETH_RX_FRMCNT_EN
   logic [31:0] frame_cnt_q;

   // Counts completed status packets; wraps naturally at 2^32.
   always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
      if (!s2mm_resetn)                           frame_cnt_q <= 32'h0;
      else if (sts_fire && (idx_q == LAST_WORD)) frame_cnt_q <= frame_cnt_q + 32'd1;
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_axi_eth_rx_sts.sv
// ---------------------------------------------------------------------------
// tb_axi_eth_rx_sts
//
// Directed, table-driven bench for axi_eth_rx_sts. Each table row describes
// a frame (beat count, last-beat tkeep, good flag, optional stalls) and the
// hand-computed status words 3 and 4. Byte n of every frame has value n.
// Hand-written sequences cover early rxs, blocking of the next frame, and
// reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_axi_eth_rx_sts;

   logic        s2mm_clk;
   logic        s2mm_resetn;
   logic [63:0] s_rxd_tdata;
   logic [7:0]  s_rxd_tkeep;
   logic        s_rxd_tlast;
   logic        s_rxd_tvalid;
   logic        s_rxd_tready;
   logic [31:0] s_rxs_tdata;
   logic        s_rxs_tvalid;
   logic        s_rxs_tready;
   logic [63:0] m_rxd_tdata;
   logic [7:0]  m_rxd_tkeep;
   logic        m_rxd_tlast;
   logic        m_rxd_tvalid;
   logic        m_rxd_tready;
   logic [31:0] m_sts_tdata;
   logic [3:0]  m_sts_tkeep;
   logic        m_sts_tlast;
   logic        m_sts_tvalid;
   logic        m_sts_tready;

   int checks_total;
   int checks_passed;
   int frames_done;

`ifdef AXI_ETH_RX_FRMCNT_EN
   localparam bit FRMCNT = 1'b1;
`else
   localparam bit FRMCNT = 1'b0;
`endif

   typedef struct {
      int          nbeats;
      logic [7:0]  last_keep;
      logic        good;
      int          stall_beat;
      int          stall_word;
      logic [31:0] exp_w3;
      logic [31:0] exp_w4;
   } vec_t;

   vec_t vecs[6];

   axi_eth_rx_sts dut (
      .s2mm_clk     (s2mm_clk),
      .s2mm_resetn  (s2mm_resetn),
      .s_rxd_tdata  (s_rxd_tdata),
      .s_rxd_tkeep  (s_rxd_tkeep),
      .s_rxd_tlast  (s_rxd_tlast),
      .s_rxd_tvalid (s_rxd_tvalid),
      .s_rxd_tready (s_rxd_tready),
      .s_rxs_tdata  (s_rxs_tdata),
      .s_rxs_tvalid (s_rxs_tvalid),
      .s_rxs_tready (s_rxs_tready),
      .m_rxd_tdata  (m_rxd_tdata),
      .m_rxd_tkeep  (m_rxd_tkeep),
      .m_rxd_tlast  (m_rxd_tlast),
      .m_rxd_tvalid (m_rxd_tvalid),
      .m_rxd_tready (m_rxd_tready),
      .m_sts_tdata  (m_sts_tdata),
      .m_sts_tkeep  (m_sts_tkeep),
      .m_sts_tlast  (m_sts_tlast),
      .m_sts_tvalid (m_sts_tvalid),
      .m_sts_tready (m_sts_tready)
   );

   // 100 MHz clock.
   initial s2mm_clk = 1'b0;
   always #5 s2mm_clk = ~s2mm_clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      else
         checks_passed++;
   endtask

   task automatic failTimeout(input string name);
      checks_total++;
      $display("[TB] FAIL %s: timed out waiting on DUT handshake", name);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   endtask

   // Presents one beat (bytes b*8..b*8+7) and waits for it to be taken.
   // stall_cycles holds m_rxd_tready low first. Returns at posedge+1.
   task automatic sendBeat(input int b, input logic [7:0] keep, input logic last,
                           input int stall_cycles, input bit rxs_early);
      logic [63:0] beat_data;
      int          waited;
      int          stall_left;
      for (int l = 0; l < 8; l++) beat_data[l*8 +: 8] = 8'(b*8 + l);
      s_rxd_tdata  = beat_data;
      s_rxd_tkeep  = keep;
      s_rxd_tlast  = last;
      s_rxd_tvalid = 1'b1;
      stall_left   = stall_cycles;
      m_rxd_tready = (stall_left == 0);
      waited       = 0;
      forever begin
         @(negedge s2mm_clk);
         if (rxs_early) checkOutput("rxs_tready_before_wait", 64'(s_rxs_tready), 64'd0);
         if (!m_rxd_tready) begin
            checkOutput("rxd_tready_stalled", 64'(s_rxd_tready), 64'd0);
            checkOutput("rxd_tvalid_stalled", 64'(m_rxd_tvalid), 64'd1);
            stall_left--;
         end else if (s_rxd_tready) begin
            checkOutput("rxd_tvalid_pass", 64'(m_rxd_tvalid), 64'd1);
            checkOutput("rxd_tdata_pass", m_rxd_tdata, beat_data);
            checkOutput("rxd_tkeep_pass", 64'(m_rxd_tkeep), 64'(keep));
            checkOutput("rxd_tlast_pass", 64'(m_rxd_tlast), 64'(last));
            @(posedge s2mm_clk);
            #1;
            break;
         end
         waited++;
         if (waited > 50) failTimeout("rxd_beat_accept");
         @(posedge s2mm_clk);
         #1;
         m_rxd_tready = (stall_left <= 0);
      end
      s_rxd_tvalid = 1'b0;
      s_rxd_tlast  = 1'b0;
      m_rxd_tready = 1'b1;
   endtask

   // Sends a whole frame and then its ifm status word.
   task automatic applyStimulus(input int nbeats, input logic [7:0] last_keep, input logic good,
                                input int stall_beat, input bit rxs_early);
      int waited;
      s_rxs_tdata = {good, 31'h1234567};
      if (rxs_early) s_rxs_tvalid = 1'b1;
      for (int b = 0; b < nbeats; b++)
         sendBeat(b, (b == nbeats - 1) ? last_keep : 8'hFF, (b == nbeats - 1),
                  (b == stall_beat) ? 2 : 0, rxs_early);
      s_rxs_tvalid = 1'b1;
      waited = 0;
      forever begin
         @(negedge s2mm_clk);
         if (s_rxs_tready) begin
            checkOutput("rxd_tready_in_wait", 64'(s_rxd_tready), 64'd0);
            @(posedge s2mm_clk);
            #1;
            break;
         end
         waited++;
         if (waited > 50) failTimeout("rxs_accept");
         @(posedge s2mm_clk);
         #1;
      end
      s_rxs_tvalid = 1'b0;
   endtask

   // Collects and checks the 6-word status packet. stall_word holds
   // m_sts_tready low for 3 cycles on that word; probe_next presents a
   // next-frame beat throughout, which must stay blocked.
   task automatic checkStatus(input logic [31:0] exp_w3, input logic [31:0] exp_w4,
                              input int stall_word, input bit probe_next);
      logic [31:0] exp_word;
      int          stall_left;
      int          waited;
      for (int w = 0; w < 6; w++) begin
         case (w)
            0:       exp_word = 32'h5000_0000;
            3:       exp_word = exp_w3;
            4:       exp_word = exp_w4;
            5:       exp_word = FRMCNT ? 32'(frames_done) : 32'h0;
            default: exp_word = 32'h0;
         endcase
         stall_left   = (w == stall_word) ? 3 : 0;
         m_sts_tready = (stall_left == 0);
         if (probe_next) begin
            s_rxd_tdata  = 64'hA5A5_0000_FFFF_5A5A;
            s_rxd_tkeep  = 8'hFF;
            s_rxd_tvalid = 1'b1;
         end
         waited = 0;
         forever begin
            @(negedge s2mm_clk);
            checkOutput("sts_tvalid", 64'(m_sts_tvalid), 64'd1);
            checkOutput($sformatf("sts_word%0d", w), 64'(m_sts_tdata), 64'(exp_word));
            checkOutput("sts_tlast", 64'(m_sts_tlast), 64'(w == 5));
            checkOutput("sts_tkeep", 64'(m_sts_tkeep), 64'hF);
            if (probe_next) begin
               checkOutput("next_frame_tready_blocked", 64'(s_rxd_tready), 64'd0);
               checkOutput("next_frame_tvalid_blocked", 64'(m_rxd_tvalid), 64'd0);
            end
            if (m_sts_tready) begin
               @(posedge s2mm_clk);
               #1;
               break;
            end
            stall_left--;
            waited++;
            if (waited > 50) failTimeout("sts_word_accept");
            @(posedge s2mm_clk);
            #1;
            m_sts_tready = (stall_left <= 0);
         end
      end
      s_rxd_tvalid = 1'b0;
      m_sts_tready = 1'b1;
      frames_done++;
      @(negedge s2mm_clk);
      checkOutput("sts_tvalid_after_packet", 64'(m_sts_tvalid), 64'd0);
      checkOutput("rxd_tready_after_packet", 64'(s_rxd_tready), 64'd1);
      @(posedge s2mm_clk);
      #1;
   endtask

   // Main sequence: reset, table rows, then the hand-written corner cases.
   initial begin
      checks_total  = 0;
      checks_passed = 0;
      frames_done   = 0;

      vecs[0] = '{2,  8'hFF, 1'b1, -1, -1, 32'h0000_0E0F, 32'h0001_0010};
      vecs[1] = '{10, 8'hFF, 1'b1,  4, -1, 32'h0000_F414, 32'h0001_0050};
      vecs[2] = '{3,  8'h07, 1'b0, -1,  3, 32'h0000_3020, 32'h0000_0013};
      vecs[3] = '{1,  8'h0F, 1'b1, -1, -1, 32'h0000_0000, 32'h0001_0004};
      vecs[4] = '{2,  8'h00, 1'b1, -1, -1, 32'h0000_0000, 32'h0001_0008};
      vecs[5] = '{3,  8'h3F, 1'b1, -1, -1, 32'h0000_4448, 32'h0001_0016};

      s2mm_resetn  = 1'b0;
      s_rxd_tdata  = 64'h0706_0504_0302_0100;
      s_rxd_tkeep  = 8'hFF;
      s_rxd_tlast  = 1'b0;
      s_rxd_tvalid = 1'b1;
      s_rxs_tdata  = 32'h8000_0000;
      s_rxs_tvalid = 1'b1;
      m_rxd_tready = 1'b1;
      m_sts_tready = 1'b1;

      repeat (3) @(negedge s2mm_clk);
      checkOutput("reset_m_rxd_tvalid", 64'(m_rxd_tvalid), 64'd0);
      checkOutput("reset_m_sts_tvalid", 64'(m_sts_tvalid), 64'd0);
      checkOutput("reset_m_sts_tlast", 64'(m_sts_tlast), 64'd0);
      checkOutput("reset_s_rxs_tready", 64'(s_rxs_tready), 64'd0);
      checkOutput("reset_m_sts_tdata", 64'(m_sts_tdata), 64'd0);
      s2mm_resetn  = 1'b1;
      s_rxd_tvalid = 1'b0;
      s_rxs_tvalid = 1'b0;
      @(posedge s2mm_clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].nbeats, vecs[i].last_keep, vecs[i].good, vecs[i].stall_beat, 1'b0);
         checkStatus(vecs[i].exp_w3, vecs[i].exp_w4, vecs[i].stall_word, 1'b0);
      end

      // Early rxs (valid from before the first beat of a 6-beat frame) and a
      // next-frame beat held off for the whole status packet.
      applyStimulus(6, 8'hFF, 1'b1, -1, 1'b1);
      checkStatus(32'h0000_0011, 32'h0001_0030, -1, 1'b1);

      // Reset pulsed in the middle of a frame: outputs drop immediately and
      // the partial frame leaves no trace in the next status packet.
      sendBeat(0, 8'hFF, 1'b0, 0, 1'b0);
      sendBeat(1, 8'hFF, 1'b0, 0, 1'b0);
      s_rxd_tvalid = 1'b1;
      #2;
      s2mm_resetn = 1'b0;
      #1;
      checkOutput("midreset_m_rxd_tvalid", 64'(m_rxd_tvalid), 64'd0);
      checkOutput("midreset_m_sts_tvalid", 64'(m_sts_tvalid), 64'd0);
      checkOutput("midreset_s_rxs_tready", 64'(s_rxs_tready), 64'd0);
      checkOutput("midreset_s_rxd_tready", 64'(s_rxd_tready), 64'd0);
      repeat (2) @(negedge s2mm_clk);
      s2mm_resetn  = 1'b1;
      s_rxd_tvalid = 1'b0;
      frames_done  = 0;
      @(posedge s2mm_clk);
      #1;

      applyStimulus(2, 8'hFF, 1'b1, -1, 1'b0);
      checkStatus(32'h0000_0E0F, 32'h0001_0010, -1, 1'b0);
      applyStimulus(3, 8'h07, 1'b1, -1, 1'b0);
      checkStatus(32'h0000_3020, 32'h0001_0013, -1, 1'b0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      failTimeout("global_watchdog");
   end

endmodule
